// File: rtl/fanout_stagger_ctrl_pkg.sv
// fanout_stagger_pkg: shared state encoding and sizing helpers for the fanout sequencer
package fanout_stagger_pkg;
  localparam int MAX_BRANCH = 16;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_UP = 2'd1;
  localparam logic [1:0] ST_ON = 2'd2;
  localparam logic [1:0] ST_DOWN = 2'd3;
  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    RAMP_UP = ST_UP,
    ON = ST_ON,
    RAMP_DOWN = ST_DOWN
  } state_t;
  function automatic int gap_w(input int gap);
    return $clog2(gap + 1);
  endfunction
endpackage

// File: rtl/fanout_stagger_ctrl_if.sv
// fanout_stagger_ctrl_if: tree request/mask in, per-branch enables and status out
interface fanout_stagger_ctrl_if #(
  parameter int NUM_BRANCH = 4,
  parameter int IDX_W = NUM_BRANCH > 1 ? $clog2(NUM_BRANCH) : 1
);
  logic en_req;
  logic [NUM_BRANCH-1:0] branch_mask;
  logic [NUM_BRANCH-1:0] branch_en;
  logic busy;
  logic ready;
  logic [IDX_W-1:0] cur_idx;
  modport master (output en_req, branch_mask, input branch_en, busy, ready, cur_idx);
  modport slave (input en_req, branch_mask, output branch_en, busy, ready, cur_idx);
endinterface

// File: rtl/fanout_prio_enc.sv
// fanout_prio_enc: lowest and highest set-bit index of a vector
module fanout_prio_enc #(
  parameter int W = 4,
  parameter int IW = W > 1 ? $clog2(W) : 1
) (
  input  logic [W-1:0]  vec_i,
  output logic [IW-1:0] lo_idx_o,
  output logic          lo_v_o,
  output logic [IW-1:0] hi_idx_o,
  output logic          hi_v_o
);
  // scan downward for the lowest hit and upward for the highest; the last hit wins
  always_comb begin
    lo_idx_o = '0;
    hi_idx_o = '0;
    for (int i = W - 1; i >= 0; i--) lo_idx_o = vec_i[i] ? IW'(i) : lo_idx_o;
    for (int i = 0; i < W; i++) hi_idx_o = vec_i[i] ? IW'(i) : hi_idx_o;
  end
  assign lo_v_o = |vec_i;
  assign hi_v_o = |vec_i;
endmodule

// File: rtl/fanout_stagger_ctrl.sv
// fanout_stagger_ctrl: staggered enable/disable sequencer for buffered fanout branches
module fanout_stagger_ctrl
  import fanout_stagger_pkg::*;
#(
  parameter int NUM_BRANCH = 4,
  parameter int GAP = 3,
  parameter int IDX_W = NUM_BRANCH > 1 ? $clog2(NUM_BRANCH) : 1
) (
  input logic clk,
  input logic rst_n,
  fanout_stagger_ctrl_if.slave bus
);
  localparam int GAP_W = gap_w(GAP);
  localparam logic [GAP_W-1:0] RELOAD = GAP_W'(GAP - 1);
  state_t state_q, state_d;
  logic [NUM_BRANCH-1:0] mask_q, mask_d, en_q, en_d, up_vec, up_bit, dn_bit, en_dn;
  logic [GAP_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d, up_idx, dn_idx, up_hi_unused, dn_lo_unused;
  logic busy_q, ready_q, up_v, dn_v, up_hv_unused, dn_lv_unused;
  // in IDLE the fresh mask is used so the first enable lands on the sampling edge
  assign up_vec = (state_q == IDLE ? bus.branch_mask : mask_q) & ~en_q;
  assign up_bit = up_v ? NUM_BRANCH'(1) << up_idx : '0;
  assign dn_bit = dn_v ? NUM_BRANCH'(1) << dn_idx : '0;
  assign en_dn = en_q & ~dn_bit;
  fanout_prio_enc #(.W(NUM_BRANCH), .IW(IDX_W)) u_up (
    .vec_i(up_vec), .lo_idx_o(up_idx), .lo_v_o(up_v), .hi_idx_o(up_hi_unused), .hi_v_o(up_hv_unused)
  );
  fanout_prio_enc #(.W(NUM_BRANCH), .IW(IDX_W)) u_dn (
    .vec_i(en_q), .lo_idx_o(dn_lo_unused), .lo_v_o(dn_lv_unused), .hi_idx_o(dn_idx), .hi_v_o(dn_v)
  );
  // sequencing: one branch toggle per GAP cycles, reversals only reload the gap
  always_comb begin
    state_d = state_q;
    mask_d = mask_q;
    en_d = en_q;
    cnt_d = cnt_q;
    idx_d = idx_q;
    case (state_q)
      IDLE: if (bus.en_req) begin
        mask_d = bus.branch_mask;
        state_d = up_v ? RAMP_UP : ON;
        en_d = en_q | up_bit;
        cnt_d = RELOAD;
        idx_d = up_v ? up_idx : idx_q;
      end
      RAMP_UP: if (!bus.en_req) begin
        state_d = RAMP_DOWN;
        cnt_d = RELOAD;
      end else if (cnt_q != '0) begin
        cnt_d = cnt_q - GAP_W'(1);
      end else begin
        state_d = up_v ? RAMP_UP : ON;
        en_d = en_q | up_bit;
        cnt_d = RELOAD;
        idx_d = up_v ? up_idx : idx_q;
      end
      ON: if (!bus.en_req) begin
        state_d = en_dn == '0 ? IDLE : RAMP_DOWN;
        en_d = en_dn;
        cnt_d = RELOAD;
        idx_d = dn_v ? dn_idx : idx_q;
      end
      default: if (bus.en_req) begin
        state_d = RAMP_UP;
        cnt_d = RELOAD;
      end else if (cnt_q != '0) begin
        cnt_d = cnt_q - GAP_W'(1);
      end else begin
        state_d = en_dn == '0 ? IDLE : RAMP_DOWN;
        en_d = en_dn;
        cnt_d = RELOAD;
        idx_d = dn_v ? dn_idx : idx_q;
      end
    endcase
  end
  // state and output registers; status flags follow the next state so they stay registered
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      mask_q <= '0;
      en_q <= '0;
      cnt_q <= '0;
      idx_q <= '0;
      busy_q <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      mask_q <= mask_d;
      en_q <= en_d;
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      busy_q <= state_d == RAMP_UP || state_d == RAMP_DOWN;
      ready_q <= state_d == ON;
    end
  end
  assign bus.branch_en = en_q;
  assign bus.busy = busy_q;
  assign bus.ready = ready_q;
  assign bus.cur_idx = idx_q;
endmodule

// File: tb/tb_fanout_stagger_ctrl.sv
// tb_fanout_stagger_ctrl: directed plan plus randomized run against a timeline model
module tb_fanout_stagger_ctrl;
  localparam int NB = 4;
  localparam int GAP = 3;
  localparam int IW = 2;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  fanout_stagger_ctrl_if #(.NUM_BRANCH(NB), .IDX_W(IW)) bus ();
  fanout_stagger_ctrl #(.NUM_BRANCH(NB), .GAP(GAP), .IDX_W(IW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  int total = 0;
  int bad = 0;
  int cyc = 0;
  int m_mode = 0;
  int m_due = 0;
  int m_idx = 0;
  logic [NB-1:0] m_en = '0;
  logic [NB-1:0] m_mask = '0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h cyc=%0d", tag, got, exp, cyc);
    end
  endtask
  task automatic drop_top();
    for (int i = NB - 1; i >= 0; i--)
      if (m_en[i]) begin
        m_en[i] = 1'b0;
        m_idx = i;
        break;
      end
    m_due = cyc + GAP;
  endtask
  task automatic add_low();
    for (int i = 0; i < NB; i++)
      if (m_mask[i] && !m_en[i]) begin
        m_en[i] = 1'b1;
        m_idx = i;
        m_due = cyc + GAP;
        m_mode = 1;
        break;
      end
  endtask
  task automatic model_edge(input logic rs, input logic r, input logic [NB-1:0] m);
    cyc++;
    if (!rs) begin
      m_mode = 0;
      m_en = '0;
      m_mask = '0;
      m_idx = 0;
    end else begin
      case (m_mode)
        0: if (r) begin
          m_mask = m;
          m_mode = 2;
          add_low();
        end
        1: if (!r) begin
          m_mode = 3;
          m_due = cyc + GAP;
        end else if (cyc >= m_due) begin
          m_mode = 2;
          add_low();
        end
        2: if (!r) begin
          drop_top();
          m_mode = m_en == '0 ? 0 : 3;
        end
        default: if (r) begin
          m_mode = 1;
          m_due = cyc + GAP;
        end else if (cyc >= m_due) begin
          drop_top();
          if (m_en == '0) m_mode = 0;
        end
      endcase
    end
  endtask
  task automatic step(input logic rs, input logic r, input logic [NB-1:0] m);
    rst_n = rs;
    bus.en_req = r;
    bus.branch_mask = m;
    @(posedge clk);
    model_edge(rs, r, m);
    @(negedge clk);
    chk("m_en", bus.branch_en, m_en);
    chk("m_busy", bus.busy, m_mode == 1 || m_mode == 3);
    chk("m_ready", bus.ready, m_mode == 2);
    chk("m_idx", bus.cur_idx, m_idx);
  endtask
  initial begin
    logic r;
    logic [NB-1:0] msk;
    for (int n = 0; n < 3; n++) begin
      step(1'b0, 1'b1, 4'b1011);
      chk("rst_en", bus.branch_en, 0);
      chk("rst_busy", bus.busy, 0);
      chk("rst_ready", bus.ready, 0);
    end
    for (int n = 1; n <= 10; n++) begin
      step(1'b1, 1'b1, 4'b1011);
      chk("up_en", bus.branch_en, n < 4 ? 1 : n < 7 ? 3 : n < 10 ? 11 : 11);
      chk("up_ready", bus.ready, n == 10);
      chk("up_busy", bus.busy, n < 10);
    end
    for (int n = 0; n < 2; n++) begin
      step(1'b1, 1'b1, 4'b0000);
      chk("on_hold", bus.branch_en, 11);
    end
    for (int n = 1; n <= 7; n++) begin
      step(1'b1, 1'b0, 4'b1011);
      chk("dn_en", bus.branch_en, n < 4 ? 3 : n < 7 ? 1 : 0);
      chk("dn_ready", bus.ready, 0);
      chk("dn_busy", bus.busy, n < 7);
    end
    for (int n = 1; n <= 4; n++) step(1'b1, 1'b1, 4'b1011);
    chk("rev_pre", bus.branch_en, 3);
    for (int n = 5; n <= 14; n++) begin
      step(1'b1, 1'b0, 4'b0100);
      chk("rev_en", bus.branch_en, n < 8 ? 3 : n < 11 ? 1 : 0);
      chk("rev_busy", bus.busy, n < 11);
    end
    step(1'b1, 1'b1, 4'b0000);
    chk("m0_ready", bus.ready, 1);
    chk("m0_en", bus.branch_en, 0);
    chk("m0_busy", bus.busy, 0);
    step(1'b1, 1'b1, 4'b1111);
    chk("m0_hold", bus.busy, 0);
    step(1'b1, 1'b0, 4'b1111);
    chk("m0_off", bus.ready, 0);
    for (int n = 1; n <= 4; n++) step(1'b1, 1'b1, 4'b0111);
    chk("mid_pre", bus.branch_en, 3);
    step(1'b0, 1'b1, 4'b0111);
    chk("mid_rst_en", bus.branch_en, 0);
    chk("mid_rst_busy", bus.busy, 0);
    step(1'b1, 1'b0, 4'b0111);
    chk("mid_idle", bus.branch_en, 0);
    r = 1'b0;
    msk = '0;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 7) == 0) r = ~r;
      msk = NB'($urandom);
      step($urandom_range(0, 299) != 0, r, msk);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
